// File: rtl/pwm_btn_pkg.sv
// Shared definitions for the PWM button conditioner.
//   cmd_state_e       : command FSM states
//   LEVEL_W           : width of the duty level bus
//   REPEAT_FIRST_MULT : hold time, in PULSE_CYCLES units, before the first auto-repeat
//   REPEAT_NEXT_MULT  : spacing, in PULSE_CYCLES units, between later auto-repeats
package pwm_btn_pkg;

   localparam int LEVEL_W           = 4;
   localparam int REPEAT_FIRST_MULT = 8;
   localparam int REPEAT_NEXT_MULT  = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PULSE_INC = 2'd1,
      PULSE_DEC = 2'd2,
      WAIT_REL  = 2'd3
   } cmd_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, debounce counter and press strobe for one raw button.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   btn_raw : raw asynchronous, bouncy button input
//   btn_db  : debounced button level
//   press   : one-cycle strobe on a debounced 0->1 transition
// The press strobe is registered together with the debounced flip, so
// a raw edge appears on press 2 + DEBOUNCE_CYCLES cycles later.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_db,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         btn_db  <= 1'b0;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
         press   <= 1'b0;
         // any sample that agrees with the debounced level restarts the count
         if (sync_q2 != btn_db) begin
            if (cnt == CNT_LAST) begin
               btn_db <= sync_q2;
               cnt    <= '0;
               press  <= sync_q2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/pwm_btn_conditioner.sv
// Button front end for the PWM duty-cycle generator: debounces the inc/dec
// buttons, arbitrates presses, keeps the saturating duty level and emits
// stretched command pulses.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   inc_btn : raw increase button
//   dec_btn : raw decrease button
//   inc     : increase command, PULSE_CYCLES wide
//   dec     : decrease command, PULSE_CYCLES wide
//   level   : current duty level, 0..MAX_LEVEL
//   busy    : high while a command pulse is driven
// Optional feature: define PWM_BTN_AUTOREPEAT_EN to repeat commands while a
// button stays held (first repeat after 8*PULSE_CYCLES, then every 4*PULSE_CYCLES).
//
// state     | meaning
// IDLE      | waiting for a single press strobe
// PULSE_INC | driving inc/busy, level already incremented
// PULSE_DEC | driving dec/busy, level already decremented
// WAIT_REL  | waiting for both debounced buttons to release
module pwm_btn_conditioner
   import pwm_btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PULSE_CYCLES    = 10,
   parameter int MAX_LEVEL       = 10,
   parameter int INIT_LEVEL      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc_btn,
   input  logic               dec_btn,
   output logic               inc,
   output logic               dec,
   output logic [LEVEL_W-1:0] level,
   output logic               busy
);

   localparam int PCNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [PCNT_W-1:0]  PULSE_LAST = PCNT_W'(PULSE_CYCLES - 1);
   localparam logic [LEVEL_W-1:0] MAX_LVL    = LEVEL_W'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0] INIT_LVL   = LEVEL_W'(INIT_LEVEL);

   logic db_inc, db_dec;
   logic press_inc, press_dec;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (inc_btn),
      .btn_db  (db_inc),
      .press   (press_inc)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (dec_btn),
      .btn_db  (db_dec),
      .press   (press_dec)
   );

   cmd_state_e        state;
   logic [PCNT_W-1:0] pulse_cnt;

`ifdef PWM_BTN_AUTOREPEAT_EN
   localparam int RCNT_W = $clog2(REPEAT_FIRST_MULT * PULSE_CYCLES);
   localparam logic [RCNT_W-1:0] REP_FIRST_LAST = RCNT_W'(REPEAT_FIRST_MULT * PULSE_CYCLES - 1);
   localparam logic [RCNT_W-1:0] REP_NEXT_LAST  = RCNT_W'(REPEAT_NEXT_MULT * PULSE_CYCLES - 1);

   logic [RCNT_W-1:0] rep_cnt;
   logic              rep_dir_inc;
   logic              rep_first;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         inc       <= 1'b0;
         dec       <= 1'b0;
         busy      <= 1'b0;
         level     <= INIT_LVL;
         pulse_cnt <= '0;
`ifdef PWM_BTN_AUTOREPEAT_EN
         rep_cnt     <= '0;
         rep_dir_inc <= 1'b0;
         rep_first   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // simultaneous strobes cancel each other; limits swallow the press
               if (press_inc && !press_dec && (level < MAX_LVL)) begin
                  state     <= PULSE_INC;
                  level     <= level + 1'b1;
                  inc       <= 1'b1;
                  busy      <= 1'b1;
                  pulse_cnt <= PULSE_LAST;
`ifdef PWM_BTN_AUTOREPEAT_EN
                  rep_dir_inc <= 1'b1;
                  rep_first   <= 1'b1;
`endif
               end else if (press_dec && !press_inc && (level != '0)) begin
                  state     <= PULSE_DEC;
                  level     <= level - 1'b1;
                  dec       <= 1'b1;
                  busy      <= 1'b1;
                  pulse_cnt <= PULSE_LAST;
`ifdef PWM_BTN_AUTOREPEAT_EN
                  rep_dir_inc <= 1'b0;
                  rep_first   <= 1'b1;
`endif
               end
            end

            PULSE_INC, PULSE_DEC: begin
               if (pulse_cnt == '0) begin
                  state <= WAIT_REL;
                  inc   <= 1'b0;
                  dec   <= 1'b0;
                  busy  <= 1'b0;
`ifdef PWM_BTN_AUTOREPEAT_EN
                  rep_cnt <= rep_first ? REP_FIRST_LAST : REP_NEXT_LAST;
`endif
               end else begin
                  pulse_cnt <= pulse_cnt - 1'b1;
               end
            end

            WAIT_REL: begin
               if (!db_inc && !db_dec) begin
                  state <= IDLE;
               end
`ifdef PWM_BTN_AUTOREPEAT_EN
               else if (rep_cnt != '0) begin
                  rep_cnt <= rep_cnt - 1'b1;
               end else if (rep_dir_inc && db_inc && !db_dec && (level < MAX_LVL)) begin
                  state     <= PULSE_INC;
                  level     <= level + 1'b1;
                  inc       <= 1'b1;
                  busy      <= 1'b1;
                  pulse_cnt <= PULSE_LAST;
                  rep_first <= 1'b0;
               end else if (!rep_dir_inc && db_dec && !db_inc && (level != '0)) begin
                  state     <= PULSE_DEC;
                  level     <= level - 1'b1;
                  dec       <= 1'b1;
                  busy      <= 1'b1;
                  pulse_cnt <= PULSE_LAST;
                  rep_first <= 1'b0;
               end
`endif
            end

            default: begin
               state <= IDLE;
               inc   <= 1'b0;
               dec   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_btn_conditioner.sv
// Self-checking bench for pwm_btn_conditioner (default build, no auto-repeat).
module tb_pwm_btn_conditioner;

   localparam int DEB   = 16;
   localparam int PULSE = 10;
   localparam int MAXL  = 10;
   localparam int INITL = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       inc_btn;
   logic       dec_btn;
   logic       inc;
   logic       dec;
   logic [3:0] level;
   logic       busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pwm_btn_conditioner dut (
      .clk     (clk),
      .rst     (rst),
      .inc_btn (inc_btn),
      .dec_btn (dec_btn),
      .inc     (inc),
      .dec     (dec),
      .level   (level),
      .busy    (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // A button's debounced value follows the raw value seen two samples
   // earlier once that value has disagreed with it for DEB samples in a row.
   // Commands: accepted one cycle after a lone press, last PULSE cycles,
   // then nothing more until both debounced buttons are released.
   int m_d1[2], m_d2[2], m_db[2], m_run[2], m_press[2];
   int m_mode;   // 0 idle, 1 pulsing, 2 waiting for release
   int m_dir;    // 0 inc, 1 dec
   int m_age;
   int m_level;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            m_d1[b] = 0; m_d2[b] = 0; m_db[b] = 0; m_run[b] = 0; m_press[b] = 0;
         end
         m_mode = 0; m_dir = 0; m_age = 0; m_level = INITL;
      end else begin
         int raw[2];
         int cmp;
         raw[0] = int'(inc_btn);
         raw[1] = int'(dec_btn);
         case (m_mode)
            0: begin
               if (m_press[0] == 1 && m_press[1] == 0 && m_level < MAXL) begin
                  m_level = m_level + 1; m_dir = 0; m_mode = 1; m_age = 0;
               end else if (m_press[1] == 1 && m_press[0] == 0 && m_level > 0) begin
                  m_level = m_level - 1; m_dir = 1; m_mode = 1; m_age = 0;
               end
            end
            1: begin
               m_age = m_age + 1;
               if (m_age == PULSE) m_mode = 2;
            end
            default: begin
               if (m_db[0] == 0 && m_db[1] == 0) m_mode = 0;
            end
         endcase
         for (int b = 0; b < 2; b++) begin
            cmp = m_d2[b];
            m_d2[b] = m_d1[b];
            m_d1[b] = raw[b];
            m_press[b] = 0;
            if (cmp != m_db[b]) begin
               m_run[b] = m_run[b] + 1;
               if (m_run[b] == DEB) begin
                  m_db[b] = cmp;
                  m_run[b] = 0;
                  m_press[b] = cmp;
               end
            end else begin
               m_run[b] = 0;
            end
         end
      end
   end

   // every-cycle comparison against the model
   always @(posedge clk) begin
      logic e_inc, e_dec, e_busy;
      logic [3:0] e_lvl;
      #1;
      e_inc  = (m_mode == 1 && m_dir == 0);
      e_dec  = (m_mode == 1 && m_dir == 1);
      e_busy = (m_mode == 1);
      e_lvl  = 4'(m_level);
      chk("model_inc", inc, e_inc);
      chk("model_dec", dec, e_dec);
      chk("model_busy", busy, e_busy);
      chk("model_level", level, e_lvl);
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input int b, input logic v);
      if (b == 0) inc_btn = v;
      else if (b == 1) dec_btn = v;
      else begin inc_btn = v; dec_btn = v; end
   endtask

   task automatic watch(input int n, output int inc_rises, output int dec_rises,
                        output int first_inc, output int first_dec,
                        output int inc_hi, output int dec_hi);
      logic pi, pd;
      pi = inc; pd = dec;
      inc_rises = 0; dec_rises = 0; first_inc = -1; first_dec = -1;
      inc_hi = 0; dec_hi = 0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (inc && !pi) begin inc_rises++; if (first_inc < 0) first_inc = i; end
         if (dec && !pd) begin dec_rises++; if (first_dec < 0) first_dec = i; end
         if (inc) inc_hi++;
         if (dec) dec_hi++;
         pi = inc; pd = dec;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; inc_btn = 1'b0; dec_btn = 1'b0;
      cycles(3);
      rst = 1'b0;
      cycles(2);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int ir, dr, fi, fd, ih, dh, acc_i, acc_d, exp_lvl;
      bit seen;
      rst = 1'b1; inc_btn = 1'b1; dec_btn = 1'b0;

      // reset held while inc is pressed
      cycles(3);
      chk("rst_inc", inc, 1'b0);
      chk("rst_dec", dec, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_level", level, 4'd4);
      rst = 1'b0;
      #1;
      chk("post_rst_inc", inc, 1'b0);
      chk("post_rst_level", level, 4'd4);
      @(negedge clk);
      inc_btn = 1'b0;
      cycles(30);

      // clean inc press
      inc_btn = 1'b1;
      watch(40, ir, dr, fi, fd, ih, dh);
      inc_btn = 1'b0;
      chk("clean_inc_start", fi, 19);
      chk("clean_inc_width", ih, 10);
      chk("clean_inc_count", ir, 1);
      chk("clean_no_dec", dr, 0);
      chk("clean_level", level, 4'd5);
      cycles(40);

      // bouncing dec, then stable
      do_reset();
      acc_d = 0;
      for (int k = 0; k < 12; k++) begin
         dec_btn = (k % 2 == 0);
         watch(5, ir, dr, fi, fd, ih, dh);
         acc_d += dr + ir;
      end
      chk("bounce_no_pulse", acc_d, 0);
      dec_btn = 1'b1;
      watch(40, ir, dr, fi, fd, ih, dh);
      dec_btn = 1'b0;
      chk("bounce_dec_start", fd, 19);
      chk("bounce_dec_width", dh, 10);
      chk("bounce_level", level, 4'd3);
      cycles(40);

      // simultaneous presses cancel
      do_reset();
      set_btn(2, 1'b1);
      watch(40, ir, dr, fi, fd, ih, dh);
      set_btn(2, 1'b0);
      chk("simul_inc", ir, 0);
      chk("simul_dec", dr, 0);
      chk("simul_level", level, 4'd4);
      cycles(40);

      // reset in the middle of a pulse
      inc_btn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (inc) seen = 1'b1;
      end
      chk("midrst_pulse_seen", seen, 1'b1);
      cycles(3);
      rst = 1'b1; inc_btn = 1'b0;
      #1;
      chk("midrst_inc", inc, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_level", level, 4'd4);
      cycles(2);
      rst = 1'b0;
      cycles(5);

      // saturation at both ends
      exp_lvl = INITL;
      for (int k = 0; k < 8; k++) begin
         inc_btn = 1'b1;
         watch(40, ir, dr, fi, fd, ih, dh);
         inc_btn = 1'b0;
         if (exp_lvl < MAXL) exp_lvl++;
         chk("sat_inc_pulses", ir, (k < 6) ? 1 : 0);
         cycles(30);
      end
      chk("sat_top_level", level, 4'd10);
      for (int k = 0; k < 11; k++) begin
         dec_btn = 1'b1;
         watch(40, ir, dr, fi, fd, ih, dh);
         dec_btn = 1'b0;
         chk("sat_dec_pulses", dr, (k < 10) ? 1 : 0);
         cycles(30);
      end
      chk("sat_bottom_level", level, 4'd0);

      // long hold gives a single command
      inc_btn = 1'b1;
      watch(500, ir, dr, fi, fd, ih, dh);
      inc_btn = 1'b0;
      chk("hold_inc_count", ir, 1);
      chk("hold_level", level, 4'd1);
      cycles(40);

      // randomized presses with bounce, checked by the model every cycle
      acc_i = 0;
      for (int k = 0; k < 24; k++) begin
         int b, nb;
         b  = int'($urandom_range(0, 2));
         nb = int'($urandom_range(0, 6));
         for (int j = 0; j < nb; j++) begin
            set_btn(b, 1'b1);
            cycles(int'($urandom_range(1, 8)));
            set_btn(b, 1'b0);
            cycles(int'($urandom_range(1, 8)));
         end
         set_btn(b, 1'b1);
         watch(int'($urandom_range(5, 60)), ir, dr, fi, fd, ih, dh);
         acc_i += ir + dr;
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
            set_btn(b, 1'b0);
            cycles(int'($urandom_range(1, 6)));
            set_btn(b, 1'b1);
            cycles(int'($urandom_range(1, 6)));
         end
         set_btn(b, 1'b0);
         cycles(int'($urandom_range(5, 50)));
         chk("rand_exclusive", (inc && dec), 1'b0);
      end
      cycles(50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
